// File: rtl/avalon_operand_writer_if.sv
// Signal bundle for avalon_operand_writer: the producer-side operand stream
// (asi_*) and the Avalon-MM write master (avm_m0_*).
// The master modport is the writer's view. The slave modport is the view of
// whatever surrounds it: the producer and the Avalon slave.
interface avalon_operand_writer_if #(
  parameter int N = 32
);
  logic         asi_valid;
  logic         asi_ready;
  logic [N-1:0] asi_data_a;
  logic [N-1:0] asi_data_b;
  logic [7:0]   avm_m0_address;
  logic         avm_m0_write;
  logic [N-1:0] avm_m0_writedata;
  logic         avm_m0_waitrequest;

  modport master (
    input  asi_valid,
    input  asi_data_a,
    input  asi_data_b,
    input  avm_m0_waitrequest,
    output asi_ready,
    output avm_m0_address,
    output avm_m0_write,
    output avm_m0_writedata
  );

  modport slave (
    output asi_valid,
    output asi_data_a,
    output asi_data_b,
    output avm_m0_waitrequest,
    input  asi_ready,
    input  avm_m0_address,
    input  avm_m0_write,
    input  avm_m0_writedata
  );
endinterface

// File: rtl/avalon_operand_writer.sv
// avalon_operand_writer: buffers {A,B} operand pairs in a DEPTH-entry FIFO.
// Each pair is replayed as two Avalon-MM writes: A goes to ADDR_A, then B
// goes to ADDR_B. The writer honours avm_m0_waitrequest.
// Optional feature: define AVW_PAIR_COUNT_EN to add the 16-bit coe_pairs
// completed-pair counter port.
module avalon_operand_writer #(
  parameter int         N      = 32,
  parameter int         DEPTH  = 4,
  parameter logic [7:0] ADDR_A = 8'd0,
  parameter logic [7:0] ADDR_B = 8'd1
) (
  input  logic                     csi_clk,
  input  logic                     rsi_srst,
  avalon_operand_writer_if.master  bus
`ifdef AVW_PAIR_COUNT_EN
  ,
  output logic [15:0]              coe_pairs
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WR_A,
    WR_B
  } state_t;

  // FIFO storage. Each entry holds one operand pair in two parallel arrays.
  logic [N-1:0]  mem_a [DEPTH];
  logic [N-1:0]  mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t        state;
  logic          write_q;
  logic [7:0]    addr_q;
  logic [N-1:0]  data_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [N-1:0]  head_a;
  logic [N-1:0]  head_b;
  logic [N-1:0]  next_a;

  // Readiness comes only from the registered count. Because of this, a full
  // FIFO never accepts a pair on the same edge that it pops one.
  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign push       = bus.asi_valid && !fifo_full;

  // The head pair retires on the edge where its B write completes.
  assign pop        = (state == WR_B) && !bus.avm_m0_waitrequest;

  assign head_a     = mem_a[rd_ptr];
  assign head_b     = mem_b[rd_ptr];
  assign next_a     = mem_a[rd_ptr + PTR_ONE];

  assign bus.asi_ready        = !fifo_full;
  assign bus.avm_m0_write     = write_q;
  assign bus.avm_m0_address   = addr_q;
  assign bus.avm_m0_writedata = data_q;

  // Store accepted pairs; this RAM-style array needs no reset.
  always_ff @(posedge csi_clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.asi_data_a;
      mem_b[wr_ptr] <= bus.asi_data_b;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at DEPTH because
  // DEPTH is a power of 2.
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Write sequencer: every bus output is registered. Address and data stay
  // untouched while the slave stalls.
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      state   <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= WR_A;
            write_q <= 1'b1;
            addr_q  <= ADDR_A;
            data_q  <= head_a;
          end
        end
        WR_A: begin
          if (!bus.avm_m0_waitrequest) begin
            state  <= WR_B;
            addr_q <= ADDR_B;
            data_q <= head_b;
          end
        end
        WR_B: begin
          if (!bus.avm_m0_waitrequest) begin
            if (count > CNT_ONE) begin
              state  <= WR_A;
              addr_q <= ADDR_A;
              data_q <= next_a;
            end else begin
              state   <= IDLE;
              write_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          write_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef AVW_PAIR_COUNT_EN
  // Count completed pairs. The counter wraps from 16'hFFFF back to zero.
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      coe_pairs <= '0;
    end else if (pop) begin
      coe_pairs <= coe_pairs + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_avalon_operand_writer.sv
// Testbench for avalon_operand_writer.
// A transaction-level model runs alongside the DUT. It holds a queue of
// expected bus writes and an occupancy count, and it is checked every cycle.
// Directed scenarios add literal expectations for ordering, latency, stalls,
// backpressure and reset.
module tb_avalon_operand_writer;

  localparam int         N      = 32;
  localparam int         DEPTH  = 4;
  localparam logic [7:0] ADDR_A = 8'd0;
  localparam logic [7:0] ADDR_B = 8'd1;

  typedef struct packed {
    logic [7:0]   addr;
    logic [N-1:0] data;
  } wr_t;

  logic csi_clk  = 1'b0;
  logic rsi_srst = 1'b1;

  avalon_operand_writer_if #(.N(N)) bus ();

`ifdef AVW_PAIR_COUNT_EN
  logic [15:0] coe_pairs;
`endif

  avalon_operand_writer #(
    .N(N),
    .DEPTH(DEPTH),
    .ADDR_A(ADDR_A),
    .ADDR_B(ADDR_B)
  ) dut (
    .csi_clk(csi_clk),
    .rsi_srst(rsi_srst),
    .bus(bus)
`ifdef AVW_PAIR_COUNT_EN
    ,
    .coe_pairs(coe_pairs)
`endif
  );

  always #5 csi_clk = ~csi_clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  wr_t         exp_q[$];
  int          occ         = 0;
  logic [15:0] model_pairs = '0;
  int          idle_run    = 0;
  logic        prev_stall  = 1'b0;
  wr_t         prev_wr     = '0;
  logic        ready_now;

  // Completion log, used by the directed expectations.
  wr_t comp_wr[64];
  int  comp_edge[64];
  int  comp_n           = 0;
  int  last_accept_edge = 0;
  int  write_cycles     = 0;
  int  edge_no          = 0;

  always @(posedge csi_clk) edge_no++;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Per-cycle compare against the model, then advance the model for the next edge.
  always @(negedge csi_clk) begin
    if (edge_no > 0) begin
      check_output("asi_ready", bus.asi_ready, occ < DEPTH);
      if (exp_q.size() == 0) begin
        check_output("spurious_write", bus.avm_m0_write, 1'b0);
      end else if (bus.avm_m0_write) begin
        idle_run = 0;
        check_output("wr_addr", bus.avm_m0_address, exp_q[0].addr);
        check_output("wr_data", bus.avm_m0_writedata, exp_q[0].data);
      end else begin
        idle_run++;
        check_output("idle_gap", idle_run > 2, 1'b0);
      end
      if (prev_stall) begin
        check_output("stall_addr", bus.avm_m0_address, prev_wr.addr);
        check_output("stall_data", bus.avm_m0_writedata, prev_wr.data);
        check_output("stall_write", bus.avm_m0_write, 1'b1);
      end
`ifdef AVW_PAIR_COUNT_EN
      check_output("coe_pairs", coe_pairs, model_pairs);
`endif
    end

    if (bus.avm_m0_write === 1'b1) write_cycles++;

    if (rsi_srst) begin
      exp_q.delete();
      occ         = 0;
      model_pairs = '0;
      idle_run    = 0;
      prev_stall  = 1'b0;
    end else begin
      ready_now  = (occ < DEPTH);
      prev_stall = bus.avm_m0_write && bus.avm_m0_waitrequest;
      prev_wr    = {bus.avm_m0_address, bus.avm_m0_writedata};
      if (bus.avm_m0_write && !bus.avm_m0_waitrequest && exp_q.size() > 0) begin
        if (comp_n < 64) begin
          comp_wr[comp_n]   = {bus.avm_m0_address, bus.avm_m0_writedata};
          comp_edge[comp_n] = edge_no + 1;
          comp_n++;
        end
        if (exp_q[0].addr == ADDR_B) begin
          occ--;
          model_pairs = model_pairs + 16'd1;
        end
        void'(exp_q.pop_front());
      end
      if (bus.asi_valid && ready_now) begin
        exp_q.push_back({ADDR_A, bus.asi_data_a});
        exp_q.push_back({ADDR_B, bus.asi_data_b});
        occ++;
        last_accept_edge = edge_no + 1;
      end
    end
  end

  task automatic tick();
    @(posedge csi_clk);
    #1;
  endtask

  // Offer one pair and hold it until it is accepted, within a bounded wait.
  task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b);
    int waited;
    waited = 0;
    bus.asi_valid  = 1'b1;
    bus.asi_data_a = a;
    bus.asi_data_b = b;
    while (!bus.asi_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!bus.asi_ready) begin
      check_output("push_timeout", 1'b1, 1'b0);
    end else begin
      tick();
    end
    bus.asi_valid = 1'b0;
  endtask

  // Wait until every expected write has completed and the master is idle.
  task automatic wait_drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || bus.avm_m0_write) && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) check_output("drain_timeout", 1'b1, 1'b0);
  endtask

  int base;
  int acc;
  int wc_base;
  logic [N-1:0] exp_data4[6];

  initial begin
    bus.asi_valid          = 1'b0;
    bus.asi_data_a         = '0;
    bus.asi_data_b         = '0;
    bus.avm_m0_waitrequest = 1'b0;
    repeat (2) tick();
    check_output("reset_write", bus.avm_m0_write, 1'b0);
    check_output("reset_addr", bus.avm_m0_address, 8'd0);
    check_output("reset_data", bus.avm_m0_writedata, 32'd0);
    check_output("reset_ready", bus.asi_ready, 1'b1);
    rsi_srst = 1'b0;
    tick();

    // Single pair, no stalls.
    base = comp_n;
    apply_stimulus(32'd5, 32'd1);
    acc = last_accept_edge;
    wait_drain();
    check_output("t1_count", comp_n - base, 2);
    check_output("t1_a", comp_wr[base], {ADDR_A, 32'd5});
    check_output("t1_b", comp_wr[base+1], {ADDR_B, 32'd1});
    check_output("t1_a_latency", comp_edge[base] - acc, 2);
    check_output("t1_b_latency", comp_edge[base+1] - acc, 3);

    // Three-cycle stall while A is on the bus.
    base    = comp_n;
    wc_base = write_cycles;
    bus.avm_m0_waitrequest = 1'b1;
    apply_stimulus(32'd7, 32'd2);
    acc = last_accept_edge;
    repeat (4) tick();
    bus.avm_m0_waitrequest = 1'b0;
    wait_drain();
    check_output("t2_count", comp_n - base, 2);
    check_output("t2_a", comp_wr[base], {ADDR_A, 32'd7});
    check_output("t2_b", comp_wr[base+1], {ADDR_B, 32'd2});
    check_output("t2_a_edge", comp_edge[base] - acc, 5);
    check_output("t2_b_edge", comp_edge[base+1] - acc, 6);
    check_output("t2_write_cycles", write_cycles - wc_base, 5);

    // Fill the FIFO under a permanent stall, then release it.
    base = comp_n;
    bus.avm_m0_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(32'(10 + 2*i), 32'(11 + 2*i));
    check_output("t3_full_ready", bus.asi_ready, 1'b0);
    bus.asi_valid  = 1'b1;
    bus.asi_data_a = 32'd18;
    bus.asi_data_b = 32'd19;
    repeat (3) tick();
    check_output("t3_full_hold", bus.asi_ready, 1'b0);
    check_output("t3_no_complete", comp_n - base, 0);
    bus.avm_m0_waitrequest = 1'b0;
    apply_stimulus(32'd18, 32'd19);
    acc = last_accept_edge;
    wait_drain();
    check_output("t3_count", comp_n - base, 10);
    for (int i = 0; i < 10; i++) begin
      check_output("t3_order", comp_wr[base+i], {8'(i % 2), 32'(10 + i)});
      check_output("t3_gapless", comp_edge[base+i] - comp_edge[base], i);
    end
    check_output("t3_fifth_accept", acc - comp_edge[base+1], 1);

    // Three back-to-back pairs stream with no gaps.
    base = comp_n;
    exp_data4[0] = 32'd1; exp_data4[1] = 32'd2; exp_data4[2] = 32'd3;
    exp_data4[3] = 32'd4; exp_data4[4] = 32'd5; exp_data4[5] = 32'd6;
    apply_stimulus(32'd1, 32'd2);
    acc = last_accept_edge;
    apply_stimulus(32'd3, 32'd4);
    apply_stimulus(32'd5, 32'd6);
    wait_drain();
    check_output("t4_count", comp_n - base, 6);
    for (int i = 0; i < 6; i++) begin
      check_output("t4_order", comp_wr[base+i], {8'(i % 2), exp_data4[i]});
      check_output("t4_edge", comp_edge[base+i] - acc, i + 2);
    end
    repeat (3) tick();
    check_output("t4_idle_write", bus.avm_m0_write, 1'b0);

    // Reset while the B write is stalled, with two pairs queued.
    bus.avm_m0_waitrequest = 1'b1;
    apply_stimulus(32'd21, 32'd22);
    apply_stimulus(32'd23, 32'd24);
    bus.avm_m0_waitrequest = 1'b0;
    tick();
    bus.avm_m0_waitrequest = 1'b1;
    check_output("t5_in_wr_b_addr", bus.avm_m0_address, ADDR_B);
    check_output("t5_in_wr_b_data", bus.avm_m0_writedata, 32'd22);
    base = comp_n;
    rsi_srst = 1'b1;
    tick();
    rsi_srst = 1'b0;
    check_output("t5_write", bus.avm_m0_write, 1'b0);
    check_output("t5_ready", bus.asi_ready, 1'b1);
    bus.avm_m0_waitrequest = 1'b0;
    repeat (5) tick();
    check_output("t5_no_writes", comp_n - base, 0);
    check_output("t5_still_idle", bus.avm_m0_write, 1'b0);
`ifdef AVW_PAIR_COUNT_EN
    check_output("t5_pairs", coe_pairs, 16'd0);

    // Counter wrap from 16'hFFFF to 16'h0000.
    force dut.coe_pairs = 16'hFFFF;
    model_pairs = 16'hFFFF;
    #1;
    release dut.coe_pairs;
    check_output("t6_preload", coe_pairs, 16'hFFFF);
    apply_stimulus(32'd9, 32'd9);
    wait_drain();
    check_output("t6_wrap", coe_pairs, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so that the run cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
